// File: rtl/overflow_monitor_pkg.sv
// Shared definitions for the overflow monitor: per-channel state and the
// direction encoding of the mode input.
package overflow_monitor_pkg;

  typedef enum logic {
    EMPTY  = 1'b0,
    PRIMED = 1'b1
  } ch_state_e;

  localparam logic MODE_UP   = 1'b0;
  localparam logic MODE_DOWN = 1'b1;

endpackage

// File: rtl/overflow_channel.sv
// One monitored count: compares each valid sample against the previous one
// and records wrap events (overflow when counting up, underflow when down).
module overflow_channel
  import overflow_monitor_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int EVT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sample,
  input  logic             valid,
  input  logic             mode,
  input  logic             clr,
  output logic             wrap_pulse,
  output logic             wrap_sticky,
  output logic             at_limit,
  output logic [EVT_W-1:0] evt_cnt
);

  localparam logic [EVT_W-1:0] EVT_MAX = {EVT_W{1'b1}};

  ch_state_e        state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             mode_q, mode_d;
  logic             pulse_q, pulse_d;
  logic             sticky_q, sticky_d;
  logic             at_limit_q, at_limit_d;
  logic [EVT_W-1:0] evt_cnt_q, evt_cnt_d;

  logic mode_changed;
  logic wrapped;
  logic event_hit;

  // NOTE: every signal gets a hold/default value first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    at_limit_d = at_limit_q;
    mode_d     = mode;

    // A direction change invalidates the stored reference for this cycle.
    mode_changed = (mode != mode_q);
    wrapped      = (mode == MODE_UP) ? (sample < prev_q) : (sample > prev_q);
    event_hit    = valid && (state_q == PRIMED) && !mode_changed && wrapped;

    if (valid) begin
      prev_d     = sample;
      state_d    = PRIMED;
      at_limit_d = (mode == MODE_UP) ? (&sample) : ~(|sample);
    end else if (clr || mode_changed) begin
      state_d = EMPTY;
    end

    if (clr && !valid) at_limit_d = 1'b0;

    pulse_d = event_hit;

    // An event in the clear cycle survives the clear as the first new event.
    if (clr) begin
      sticky_d  = event_hit;
      evt_cnt_d = event_hit ? EVT_W'(1) : '0;
    end else begin
      sticky_d  = sticky_q | event_hit;
      evt_cnt_d = (event_hit && evt_cnt_q != EVT_MAX) ? evt_cnt_q + EVT_W'(1) : evt_cnt_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= EMPTY;
      prev_q     <= '0;
      mode_q     <= MODE_UP;
      pulse_q    <= 1'b0;
      sticky_q   <= 1'b0;
      at_limit_q <= 1'b0;
      evt_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      mode_q     <= mode_d;
      pulse_q    <= pulse_d;
      sticky_q   <= sticky_d;
      at_limit_q <= at_limit_d;
      evt_cnt_q  <= evt_cnt_d;
    end
  end

  assign wrap_pulse  = pulse_q;
  assign wrap_sticky = sticky_q;
  assign at_limit    = at_limit_q;
  assign evt_cnt     = evt_cnt_q;

endmodule

// File: rtl/overflow_monitor.sv
// Multi-channel wrap monitor: one overflow_channel per count plus a
// registered interrupt combining the enabled sticky flags.
module overflow_monitor
  import overflow_monitor_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int EVT_W    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] count,
  input  logic [CHANNELS-1:0]       valid,
  input  logic [CHANNELS-1:0]       mode,
  input  logic [CHANNELS-1:0]       clr,
  input  logic [CHANNELS-1:0]       irq_en,
  output logic [CHANNELS-1:0]       wrap_pulse,
  output logic [CHANNELS-1:0]       wrap_sticky,
  output logic [CHANNELS-1:0]       at_limit,
  output logic [CHANNELS*EVT_W-1:0] evt_cnt,
  output logic                      irq
);

  logic irq_q, irq_d;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    overflow_channel #(
      .WIDTH(WIDTH),
      .EVT_W(EVT_W)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .sample     (count[c*WIDTH +: WIDTH]),
      .valid      (valid[c]),
      .mode       (mode[c]),
      .clr        (clr[c]),
      .wrap_pulse (wrap_pulse[c]),
      .wrap_sticky(wrap_sticky[c]),
      .at_limit   (at_limit[c]),
      .evt_cnt    (evt_cnt[c*EVT_W +: EVT_W])
    );
  end

  always_comb begin
    irq_d = |(wrap_sticky & irq_en);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= irq_d;
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_overflow_monitor.sv
// Self-checking bench for overflow_monitor: directed scenarios plus a
// randomized run compared cycle by cycle against a behavioural model.
module tb_overflow_monitor;

  localparam int W = 8;
  localparam int C = 4;
  localparam int E = 4;
  localparam int EMAX = (1 << E) - 1;
  localparam int WMAX = (1 << W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [C*W-1:0]   count;
  logic [C-1:0]     valid, mode, clr, irq_en;
  logic [C-1:0]     wrap_pulse, wrap_sticky, at_limit;
  logic [C*E-1:0]   evt_cnt;
  logic             irq;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: what each channel remembers, in plain integers.
  bit m_primed[C];
  int m_prev[C];
  bit m_mode[C];
  bit m_pulse[C];
  bit m_sticky[C];
  bit m_atl[C];
  int m_cnt[C];
  bit m_irq;

  overflow_monitor #(.WIDTH(W), .CHANNELS(C), .EVT_W(E)) dut (
    .clk        (clk),
    .reset      (reset),
    .count      (count),
    .valid      (valid),
    .mode       (mode),
    .clr        (clr),
    .irq_en     (irq_en),
    .wrap_pulse (wrap_pulse),
    .wrap_sticky(wrap_sticky),
    .at_limit   (at_limit),
    .evt_cnt    (evt_cnt),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int c = 0; c < C; c++) begin
      m_primed[c] = 0; m_prev[c] = 0; m_mode[c] = 0;
      m_pulse[c] = 0; m_sticky[c] = 0; m_atl[c] = 0; m_cnt[c] = 0;
    end
    m_irq = 0;
  endtask

  task automatic model_edge();
    bit any_irq = 0;
    for (int c = 0; c < C; c++) if (m_sticky[c] && irq_en[c]) any_irq = 1;
    for (int c = 0; c < C; c++) begin
      int s = int'(count[c*W +: W]);
      bit changed = (mode[c] != m_mode[c]);
      bit wrap = valid[c] && m_primed[c] && !changed &&
                 (mode[c] ? (s > m_prev[c]) : (s < m_prev[c]));
      m_pulse[c] = wrap;
      if (clr[c]) begin
        m_sticky[c] = wrap;
        m_cnt[c]    = wrap ? 1 : 0;
      end else begin
        m_sticky[c] = m_sticky[c] | wrap;
        if (wrap && m_cnt[c] < EMAX) m_cnt[c]++;
      end
      if (valid[c]) begin
        m_atl[c]    = mode[c] ? (s == 0) : (s == WMAX);
        m_prev[c]   = s;
        m_primed[c] = 1;
      end else begin
        if (clr[c]) m_atl[c] = 0;
        if (clr[c] || changed) m_primed[c] = 0;
      end
      m_mode[c] = mode[c];
    end
    m_irq = any_irq;
  endtask

  // One clock: inputs already driven, model follows the edge, outputs sampled #1 later.
  task automatic step();
    @(posedge clk);
    if (reset) model_reset(); else model_edge();
    #1;
  endtask

  task automatic idle();
    valid = '0;
    clr   = '0;
  endtask

  task automatic sample(input int c, input int v);
    idle();
    valid[c] = 1'b1;
    count[c*W +: W] = W'(v);
    step();
  endtask

  function automatic int cnt_of(input int c);
    return int'(evt_cnt[c*E +: E]);
  endfunction

  task automatic test_reset();
    reset = 1'b1; count = '0; valid = '0; mode = '0; clr = '0; irq_en = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks += 5;
    if (wrap_pulse !== '0)  begin n_fail++; $display("FAIL reset_pulse got %h want 0", wrap_pulse); end
    if (wrap_sticky !== '0) begin n_fail++; $display("FAIL reset_sticky got %h want 0", wrap_sticky); end
    if (at_limit !== '0)    begin n_fail++; $display("FAIL reset_at_limit got %h want 0", at_limit); end
    if (evt_cnt !== '0)     begin n_fail++; $display("FAIL reset_evt_cnt got %h want 0", evt_cnt); end
    if (irq !== 1'b0)       begin n_fail++; $display("FAIL reset_irq got %b want 0", irq); end
    reset = 1'b0;
  endtask

  task automatic test_up_wrap();
    sample(0, 'h2A);
    n_checks += 2;
    if (wrap_pulse[0] !== 1'b0) begin n_fail++; $display("FAIL up_prime_pulse got %b want 0", wrap_pulse[0]); end
    if (at_limit[0] !== 1'b0)   begin n_fail++; $display("FAIL up_2a_at_limit got %b want 0", at_limit[0]); end
    sample(0, 'hFF);
    n_checks += 2;
    if (wrap_pulse[0] !== 1'b0) begin n_fail++; $display("FAIL up_ff_pulse got %b want 0", wrap_pulse[0]); end
    if (at_limit[0] !== 1'b1)   begin n_fail++; $display("FAIL up_ff_at_limit got %b want 1", at_limit[0]); end
    sample(0, 'h00);
    n_checks += 4;
    if (wrap_pulse[0] !== 1'b1)  begin n_fail++; $display("FAIL up_wrap_pulse got %b want 1", wrap_pulse[0]); end
    if (wrap_sticky[0] !== 1'b1) begin n_fail++; $display("FAIL up_wrap_sticky got %b want 1", wrap_sticky[0]); end
    if (cnt_of(0) !== 1)         begin n_fail++; $display("FAIL up_wrap_cnt got %0d want 1", cnt_of(0)); end
    if (at_limit[0] !== 1'b0)    begin n_fail++; $display("FAIL up_00_at_limit got %b want 0", at_limit[0]); end
    idle(); step();
    n_checks += 2;
    if (wrap_pulse[0] !== 1'b0)  begin n_fail++; $display("FAIL up_pulse_width got %b want 0", wrap_pulse[0]); end
    if (wrap_sticky[0] !== 1'b1) begin n_fail++; $display("FAIL up_sticky_hold got %b want 1", wrap_sticky[0]); end
    clr[0] = 1'b1; step(); idle();
  endtask

  task automatic test_down_irq();
    mode[1] = 1'b1; irq_en[1] = 1'b1;
    sample(1, 'h05);
    sample(1, 'h00);
    n_checks += 2;
    if (wrap_pulse[1] !== 1'b0) begin n_fail++; $display("FAIL down_dec_pulse got %b want 0", wrap_pulse[1]); end
    if (at_limit[1] !== 1'b1)   begin n_fail++; $display("FAIL down_zero_at_limit got %b want 1", at_limit[1]); end
    sample(1, 'hFE);
    n_checks += 3;
    if (wrap_pulse[1] !== 1'b1) begin n_fail++; $display("FAIL down_wrap_pulse got %b want 1", wrap_pulse[1]); end
    if (cnt_of(1) !== 1)        begin n_fail++; $display("FAIL down_wrap_cnt got %0d want 1", cnt_of(1)); end
    if (irq !== 1'b0)           begin n_fail++; $display("FAIL irq_latency got %b want 0", irq); end
    idle(); step();
    n_checks += 1;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_assert got %b want 1", irq); end
    clr[1] = 1'b1; step(); idle();
    n_checks += 2;
    if (wrap_sticky[1] !== 1'b0) begin n_fail++; $display("FAIL down_clr_sticky got %b want 0", wrap_sticky[1]); end
    if (cnt_of(1) !== 0)         begin n_fail++; $display("FAIL down_clr_cnt got %0d want 0", cnt_of(1)); end
    step();
    n_checks += 1;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_deassert got %b want 0", irq); end
    irq_en[1] = 1'b0; mode[1] = 1'b0; step();
  endtask

  task automatic test_saturate();
    sample(2, 'h80);
    for (int i = 1; i <= 20; i++) begin
      sample(2, 'h10);
      if (i == 15 || i == 16) begin
        n_checks += 1;
        if (cnt_of(2) !== 15) begin n_fail++; $display("FAIL sat_cnt_%0d got %0d want 15", i, cnt_of(2)); end
      end
      sample(2, 'h80);
    end
    n_checks += 2;
    if (cnt_of(2) !== 15)        begin n_fail++; $display("FAIL sat_cnt_final got %0d want 15", cnt_of(2)); end
    if (wrap_sticky[2] !== 1'b1) begin n_fail++; $display("FAIL sat_sticky got %b want 1", wrap_sticky[2]); end
    idle(); clr[2] = 1'b1; step(); idle();
  endtask

  task automatic test_clr_collision();
    sample(0, 'h50);
    idle(); valid[0] = 1'b1; clr[0] = 1'b1; count[0 +: W] = W'('h20); step();
    n_checks += 3;
    if (wrap_pulse[0] !== 1'b1)  begin n_fail++; $display("FAIL clr_coll_pulse got %b want 1", wrap_pulse[0]); end
    if (wrap_sticky[0] !== 1'b1) begin n_fail++; $display("FAIL clr_coll_sticky got %b want 1", wrap_sticky[0]); end
    if (cnt_of(0) !== 1)         begin n_fail++; $display("FAIL clr_coll_cnt got %0d want 1", cnt_of(0)); end
    mode[0] = 1'b1; sample(0, 'h10);
    mode[0] = 1'b0; sample(0, 'h05);
    n_checks += 2;
    if (wrap_pulse[0] !== 1'b0) begin n_fail++; $display("FAIL mode_toggle_pulse got %b want 0", wrap_pulse[0]); end
    if (cnt_of(0) !== 1)        begin n_fail++; $display("FAIL mode_toggle_cnt got %0d want 1", cnt_of(0)); end
    sample(0, 'h01);
    n_checks += 1;
    if (cnt_of(0) !== 2) begin n_fail++; $display("FAIL reprimed_cnt got %0d want 2", cnt_of(0)); end
    idle(); clr[0] = 1'b1; step(); idle();
  endtask

  task automatic test_reset_mid();
    irq_en[3] = 1'b1;
    sample(3, 'hF0);
    idle();
    reset = 1'b1;
    model_reset();
    #1;
    n_checks += 5;
    if (wrap_pulse !== '0)  begin n_fail++; $display("FAIL mid_reset_pulse got %h want 0", wrap_pulse); end
    if (wrap_sticky !== '0) begin n_fail++; $display("FAIL mid_reset_sticky got %h want 0", wrap_sticky); end
    if (at_limit !== '0)    begin n_fail++; $display("FAIL mid_reset_at_limit got %h want 0", at_limit); end
    if (evt_cnt !== '0)     begin n_fail++; $display("FAIL mid_reset_evt_cnt got %h want 0", evt_cnt); end
    if (irq !== 1'b0)       begin n_fail++; $display("FAIL mid_reset_irq got %b want 0", irq); end
    step();
    reset = 1'b0;
    sample(3, 'h10);
    idle(); step();
    n_checks += 3;
    if (wrap_sticky[3] !== 1'b0) begin n_fail++; $display("FAIL post_reset_sticky got %b want 0", wrap_sticky[3]); end
    if (cnt_of(3) !== 0)         begin n_fail++; $display("FAIL post_reset_cnt got %0d want 0", cnt_of(3)); end
    if (irq !== 1'b0)            begin n_fail++; $display("FAIL post_reset_irq got %b want 0", irq); end
    irq_en[3] = 1'b0;
  endtask

  task automatic test_random();
    logic [C-1:0] exp_pulse, exp_sticky, exp_atl;
    logic [C*E-1:0] exp_cnt;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int c = 0; c < C; c++) begin
        int r = int'($urandom_range(0, 7));
        valid[c] = ($urandom_range(0, 3) != 0);
        clr[c]   = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 15) == 0) mode[c] = ~mode[c];
        if ($urandom_range(0, 31) == 0) irq_en[c] = ~irq_en[c];
        count[c*W +: W] = (r == 0) ? W'(0) : (r == 1) ? W'(WMAX) : W'($urandom);
      end
      if (cyc % 200 == 150) begin
        reset = 1'b1; model_reset();
      end
      step();
      reset = 1'b0;
      for (int c = 0; c < C; c++) begin
        exp_pulse[c]  = m_pulse[c];
        exp_sticky[c] = m_sticky[c];
        exp_atl[c]    = m_atl[c];
        exp_cnt[c*E +: E] = E'(m_cnt[c]);
      end
      n_checks += 5;
      if (wrap_pulse !== exp_pulse)   begin n_fail++; $display("FAIL rnd_pulse cyc %0d got %h want %h", cyc, wrap_pulse, exp_pulse); end
      if (wrap_sticky !== exp_sticky) begin n_fail++; $display("FAIL rnd_sticky cyc %0d got %h want %h", cyc, wrap_sticky, exp_sticky); end
      if (at_limit !== exp_atl)       begin n_fail++; $display("FAIL rnd_at_limit cyc %0d got %h want %h", cyc, at_limit, exp_atl); end
      if (evt_cnt !== exp_cnt)        begin n_fail++; $display("FAIL rnd_evt_cnt cyc %0d got %h want %h", cyc, evt_cnt, exp_cnt); end
      if (irq !== m_irq)              begin n_fail++; $display("FAIL rnd_irq cyc %0d got %b want %b", cyc, irq, m_irq); end
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_irq();
    test_saturate();
    test_clr_collision();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/overflow_monitor.md
OVERFLOW_MONITOR -- requirements
Module: overflow_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning bit width of each monitored count.
REQ-002 SHALL have parameter CHANNELS, default 4, meaning number of independent monitored counts.
REQ-003 SHALL have parameter EVT_W, default 4, meaning width of each per-channel saturating event counter.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port count  input  CHANNELS*WIDTH  packed samples; channel c occupies bits [c*WIDTH +: WIDTH].
REQ-007 SHALL have port valid  input  CHANNELS  per-channel sample strobe.
REQ-008 SHALL have port mode  input  CHANNELS  per-channel direction: 0 = up-counter (detect overflow), 1 = down-counter (detect underflow).
REQ-009 SHALL have port clr  input  CHANNELS  per-channel clear of sticky flag, event count and history.
REQ-010 SHALL have port irq_en  input  CHANNELS  per-channel interrupt enable.
REQ-011 SHALL have port wrap_pulse  output  CHANNELS  one-cycle wrap-event strobe.
REQ-012 SHALL have port wrap_sticky  output  CHANNELS  latched wrap-event flag.
REQ-013 SHALL have port at_limit  output  CHANNELS  last sample equals all-ones (up) or zero (down).
REQ-014 SHALL have port evt_cnt  output  CHANNELS*EVT_W  packed saturating wrap-event counts.
REQ-015 SHALL have port irq  output  1  OR over channels of wrap_sticky & irq_en.

Function
REQ-016 Each channel SHALL hold state EMPTY (no reference sample) or PRIMED (prev sample stored).
REQ-017 EMPTY + valid: store sample, go PRIMED, no event.
REQ-018 PRIMED + valid, mode 0: wrap event iff sample < prev (unsigned); mode 1: wrap event iff sample > prev; prev updated to sample every valid cycle.
REQ-019 Sample equal to prev SHALL NOT be an event; a sample with valid low SHALL be ignored entirely.
REQ-020 wrap_pulse[c] SHALL assert exactly the cycle after the sampling edge (1-cycle latency) and deassert the following cycle unless another event occurs.
REQ-021 wrap_sticky[c] SHALL set on event and hold until clr[c]; clr and event in the same cycle: sticky remains set, evt_cnt becomes 1.
REQ-022 evt_cnt[c] SHALL increment per event and saturate at 2^EVT_W-1 (no wrap).
REQ-023 at_limit[c] SHALL be registered from each valid sample (1-cycle latency), held otherwise.
REQ-024 clr[c] SHALL return the channel to EMPTY, clear at_limit, sticky and evt_cnt (subject to REQ-021); a valid sample in the clr cycle SHALL be stored as the new reference without event unless REQ-021 applies to an event computed against the old prev.
REQ-025 A change of mode[c] between consecutive registered values SHALL force the channel to EMPTY; the sample in that cycle primes the channel, no event.
REQ-026 irq SHALL be registered: asserts the cycle after any enabled sticky bit is set, deasserts the cycle after all enabled sticky bits clear or irq_en drops.
REQ-027 Channels SHALL be fully independent; simultaneous events on all channels SHALL all be recorded.

Reset
REQ-028 reset high SHALL asynchronously force all channels EMPTY, prev to 0, stored mode to 0, and wrap_pulse, wrap_sticky, at_limit, evt_cnt, irq to 0.
REQ-029 Reset asserted mid-operation SHALL discard history; first valid sample after release SHALL only prime.

Structure
REQ-030 A shared package overflow_monitor_pkg SHALL hold the channel-state enum (EMPTY, PRIMED) and the mode encoding constants (MODE_UP = 0, MODE_DOWN = 1).
REQ-031 Per-channel logic SHALL be sub-module overflow_channel (parameters WIDTH, EVT_W), instantiated CHANNELS times by generate; top holds packing and irq register only.

Verification
REQ-032 Reset, ch0 mode 0, valid samples 0x2A, 0xFF, 0x00 -> wrap_pulse[0] one cycle after 0x00, sticky[0]=1, evt_cnt[0]=1, at_limit[0]=1 after 0xFF then 0.
REQ-033 ch1 mode 1, samples 0x05, 0x00, 0xFE -> one underflow event, evt_cnt[1]=1; irq_en[1]=1 gives irq=1 next cycle; clr[1] -> sticky[1]=0, irq=0 next cycle.
REQ-034 EVT_W=4, 20 wrap events on ch2 -> evt_cnt[2] holds 15, no rollover.
REQ-035 clr[0] in same cycle as wrap sample -> sticky[0]=1, evt_cnt[0]=1; toggle mode[0] then sample lower value -> no event.
REQ-036 Assert reset between samples 0xF0 and 0x10 -> no event after release; all outputs 0 during reset.
